// File: rtl/byte_time_pkg.sv
// Shared types for the byte/timestamp sink.
// Entry layout and flag bit positions.
package byte_time_pkg;

  localparam int BT_TIME_W = 64;

  localparam int FLAG_FULL  = 1;
  localparam int FLAG_EMPTY = 0;

  typedef struct packed {
    byte         data;
    logic [63:0] stamp;
  } bt_entry_t;

endpackage

// File: rtl/byte_time_sink_if.sv
// Upstream/downstream handshake bundle for byte_time_sink.
// stall_cnt exists only with BYTE_TIME_SINK_STALL_COUNT_EN.
interface byte_time_sink_if #(
  parameter int TIME_W = 64
);

  logic              in_valid;
  byte               in_data;
  logic              in_ready;
  logic              out_valid;
  byte               out_data;
  logic [TIME_W-1:0] out_time;
  logic              out_ready;
  logic [1:0]        flags;
  logic [TIME_W-1:0] now;
`ifdef BYTE_TIME_SINK_STALL_COUNT_EN
  logic [31:0]       stall_cnt;
`endif

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_time,
    input  out_ready,
    output flags,
`ifdef BYTE_TIME_SINK_STALL_COUNT_EN
    output stall_cnt,
`endif
    output now
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_time,
    output out_ready,
    input  flags,
`ifdef BYTE_TIME_SINK_STALL_COUNT_EN
    input  stall_cnt,
`endif
    input  now
  );

endinterface

// File: rtl/bt_fifo.sv
// First-word-fall-through FIFO with wrapping pointers and count.
// Push is refused when full and pop when empty.
module bt_fifo
  import byte_time_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = bt_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  T           mem_q [DEPTH];
  T           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case (1'b1)
      push_ok && !pop_ok: cnt_d = cnt_q + CNT_W'(1);
      pop_ok && !push_ok: cnt_d = cnt_q - CNT_W'(1);
      default:            cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; the pointers define what is live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/byte_time_sink.sv
// Stamps incoming bytes with a free-running cycle count and queues them.
// Optional stall counter: define BYTE_TIME_SINK_STALL_COUNT_EN.
module byte_time_sink
  import byte_time_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TIME_W = BT_TIME_W
) (
  input logic              clk,
  input logic              rst,
  byte_time_sink_if.slave  bus
);

  logic [TIME_W-1:0] now_q, now_d;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [1:0]        flags;
  bt_entry_t         wr_e;
  bt_entry_t         rd_e;

  always_comb begin
    now_d      = now_q + TIME_W'(1);
    push       = bus.in_valid && !full;
    pop        = !empty && bus.out_ready;
    wr_e       = '0;
    wr_e.data  = bus.in_data;
    wr_e.stamp = 64'(now_q);
    flags             = '0;
    flags[FLAG_FULL]  = full;
    flags[FLAG_EMPTY] = empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      now_q <= '0;
    end else begin
      now_q <= now_d;
    end
  end

  bt_fifo #(
    .DEPTH (DEPTH),
    .T     (bt_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_e),
    .pop   (pop),
    .rdata (rd_e),
    .full  (full),
    .empty (empty)
  );

  // Head is masked while empty so idle outputs read as zero.
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? 8'sd0 : rd_e.data;
  assign bus.out_time  = empty ? '0 : rd_e.stamp[TIME_W-1:0];
  assign bus.flags     = flags;
  assign bus.now       = now_q;

`ifdef BYTE_TIME_SINK_STALL_COUNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (bus.in_valid && full && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign bus.stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_byte_time_sink.sv
// Directed bench for byte_time_sink: reset, latency, fill/stall,
// pop-while-full, steady streaming and reset with data in flight.
module tb_byte_time_sink;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  byte_time_sink_if #(.TIME_W(64)) bus ();

  byte_time_sink #(
    .DEPTH  (4),
    .TIME_W (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] od();
    return {56'h0, bus.out_data};
  endfunction

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'sh00;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_now", bus.now, 64'd0);
    chk("rst_flags", {62'h0, bus.flags}, 64'd1);
    chk("rst_oval", {63'h0, bus.out_valid}, 64'd0);
    chk("rst_irdy", {63'h0, bus.in_ready}, 64'd1);
    chk("rst_odata", od(), 64'd0);
    chk("rst_otime", bus.out_time, 64'd0);

    for (int i = 0; i < 5; i++) tick();
    chk("idle_now", bus.now, 64'd5);
    chk("idle_flags", {62'h0, bus.flags}, 64'd1);
    chk("idle_oval", {63'h0, bus.out_valid}, 64'd0);
    chk("idle_irdy", {63'h0, bus.in_ready}, 64'd1);

    // single byte stamped at now=3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("one_now", bus.now, 64'd3);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'shA5;
    tick();
    bus.in_valid = 1'b0;
    chk("one_oval", {63'h0, bus.out_valid}, 64'd1);
    chk("one_odata", od(), 64'hA5);
    chk("one_otime", bus.out_time, 64'd3);
    chk("one_flags", {62'h0, bus.flags}, 64'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("one_pop_flags", {62'h0, bus.flags}, 64'd1);
    chk("one_pop_oval", {63'h0, bus.out_valid}, 64'd0);

    // fill with out_ready low
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.in_data = byte'(i);
      tick();
    end
    chk("full_flags", {62'h0, bus.flags}, 64'd2);
    chk("full_irdy", {63'h0, bus.in_ready}, 64'd0);
    chk("full_head", od(), 64'h01);
    bus.in_data = 8'sh05;
    tick();
    tick();
    chk("stall_flags", {62'h0, bus.flags}, 64'd2);
    chk("stall_head", od(), 64'h01);
`ifdef BYTE_TIME_SINK_STALL_COUNT_EN
    chk("stall_cnt2", {32'h0, bus.stall_cnt}, 64'd2);
`endif

    // pop while full: no push in the same cycle
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("pf_head", od(), 64'h02);
    chk("pf_flags", {62'h0, bus.flags}, 64'd0);
    chk("pf_irdy", {63'h0, bus.in_ready}, 64'd1);
`ifdef BYTE_TIME_SINK_STALL_COUNT_EN
    chk("stall_cnt3", {32'h0, bus.stall_cnt}, 64'd3);
`endif
    tick();
    bus.in_valid = 1'b0;
    chk("pf_refill", {62'h0, bus.flags}, 64'd2);
    bus.out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("order", od(), 64'(i));
      tick();
    end
    bus.out_ready = 1'b0;
    chk("drain_flags", {62'h0, bus.flags}, 64'd1);

    // streaming at half full
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'sh10;
    tick();
    bus.in_data  = 8'sh11;
    tick();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("st_data", od(), 64'(8'h10 + i));
      chk("st_time", bus.out_time, 64'(i));
      chk("st_flags", {62'h0, bus.flags}, 64'd0);
      chk("st_now", bus.now, 64'(i + 2));
      bus.in_data = byte'(8'h12 + i);
      tick();
    end

    // reset with three entries and in_valid high
    bus.out_ready = 1'b0;
    bus.in_data   = 8'sh7E;
    tick();
    chk("pre_rst_flags", {62'h0, bus.flags}, 64'd0);
    rst = 1'b1;
    tick();
    chk("rr_flags", {62'h0, bus.flags}, 64'd1);
    chk("rr_oval", {63'h0, bus.out_valid}, 64'd0);
    chk("rr_now", bus.now, 64'd0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rr_quiet", {63'h0, bus.out_valid}, 64'd0);
    end
    chk("rr_now3", bus.now, 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
